// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for the register bank write port with clear sweep and sticky select error
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG = 6,
  parameter int NUM_REQ = 3,
  localparam int SEL_W = $clog2(NUM_REG),
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*SEL_W-1:0]      i_req_select,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_clear,
  input  logic                          i_err_clear,
  output logic                          o_write_enable,
  output logic [SEL_W-1:0]              o_write_select,
  output logic [DATA_WIDTH-1:0]         o_write_data,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [IDX_W-1:0]              o_err_src
);
  localparam logic [SEL_W:0] NREG = (SEL_W+1)'(NUM_REG);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REG - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, win;
  logic [SEL_W-1:0] cnt, cnt_nx, sel_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic grant, bad, sweep, last;
  assign sweep = state == CLEAR;
  assign last = cnt == LAST_SEL;
  assign o_busy = sweep;
  assign bad = grant && ({1'b0, sel_w} >= NREG);
  // winner is the valid requester at the smallest rotated distance from the pointer
  always_comb begin
    int best, d;
    best = NUM_REQ;
    d = 0;
    win = '0;
    sel_w = '0;
    data_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(ptr);
      d = d < 0 ? d + NUM_REQ : d;
      if (i_req_valid[i] && d < best) begin
        best = d;
        win = IDX_W'(i);
      end
    end
    grant = !rst && state == IDLE && !i_clear && best < NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = grant && win == IDX_W'(i);
      if (win == IDX_W'(i)) begin
        sel_w = i_req_select[i*SEL_W +: SEL_W];
        data_w = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE) state_nx = i_clear ? CLEAR : IDLE;
    else begin
      state_nx = last ? IDLE : CLEAR;
      cnt_nx = last ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      o_write_enable <= 1'b0;
      o_write_select <= '0;
      o_write_data <= '0;
      o_err <= 1'b0;
      o_err_src <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (grant) ptr <= win == LAST_IDX ? '0 : win + 1'b1;
      o_write_enable <= sweep || (grant && !bad);
      if (sweep) begin
        o_write_select <= cnt;
        o_write_data <= '0;
      end else if (grant && !bad) begin
        o_write_select <= sel_w;
        o_write_data <= data_w;
      end
      // a fresh error outranks a simultaneous error clear
      if (bad) begin
        o_err <= 1'b1;
        if (!o_err || i_err_clear) o_err_src <= win;
      end else if (i_err_clear) o_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors checked per cycle against a behavioural model plus literal expectations
module tb_reg_write_arbiter;
  localparam int NREQ = 3;
  localparam int NREG = 6;
  logic clk = 0, rst = 1;
  logic [2:0] valid = 0;
  logic [8:0] sel = 0;
  logic [23:0] data = 0;
  logic clr = 0, eclr = 0;
  logic [2:0] ready;
  logic we, busy, err;
  logic [2:0] wsel;
  logic [7:0] wdata;
  logic [1:0] src;
  int checks = 0, errors = 0;

  reg_write_arbiter dut (
    .clk(clk), .rst(rst), .i_req_valid(valid), .i_req_select(sel), .i_req_data(data),
    .o_req_ready(ready), .i_clear(clr), .i_err_clear(eclr), .o_write_enable(we),
    .o_write_select(wsel), .o_write_data(wdata), .o_busy(busy), .o_err(err), .o_err_src(src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model state: what the outputs must read after the most recent edge
  int m_ptr = 0, m_left = 0, m_sel = 0, m_data = 0, m_src = 0;
  bit m_we = 0, m_err = 0;

  always @(negedge clk) begin
    int w, s;
    bit found, bad;
    found = 0;
    w = 0;
    for (int k = 0; k < NREQ; k++)
      if (!found && valid[(m_ptr + k) % NREQ]) begin
        found = 1;
        w = (m_ptr + k) % NREQ;
      end
    found = found && !rst && m_left == 0 && !clr;
    chk("m_ready", int'(ready), found ? (1 << w) : 0);
    chk("m_we", int'(we), int'(m_we));
    chk("m_sel", int'(wsel), m_sel);
    chk("m_data", int'(wdata), m_data);
    chk("m_busy", int'(busy), int'(m_left > 0));
    chk("m_err", int'(err), int'(m_err));
    chk("m_src", int'(src), m_src);
    bad = 0;
    if (rst) begin
      m_ptr = 0; m_left = 0; m_we = 0; m_sel = 0; m_data = 0; m_err = 0; m_src = 0;
    end else begin
      if (m_left > 0) begin
        m_we = 1; m_sel = NREG - m_left; m_data = 0; m_left--;
      end else if (clr) begin
        m_we = 0; m_left = NREG;
      end else if (found) begin
        m_ptr = (w + 1) % NREQ;
        s = int'(sel[w*3 +: 3]);
        bad = s >= NREG;
        m_we = !bad;
        if (!bad) begin
          m_sel = s;
          m_data = int'(data[w*8 +: 8]);
        end
      end else m_we = 0;
      if (bad) begin
        if (!m_err || eclr) m_src = w;
        m_err = 1;
      end else if (eclr) m_err = 0;
    end
  end

  initial begin
    repeat (2) step();
    rst = 0;
    repeat (3) step();
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_sel", int'(wsel), 0);
    chk("rst_data", int'(wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    step();
    valid = 3'b010; sel[5:3] = 3'd2; data[15:8] = 8'hAA;
    #1 chk("t2_ready", int'(ready), 3'b010);
    step(); valid = 0;
    #1 chk("t2_we", int'(we), 1);
    chk("t2_sel", int'(wsel), 2);
    chk("t2_data", int'(wdata), 8'hAA);
    step();
    #1 chk("t2_we_off", int'(we), 0);
    valid = 3'b001; sel[2:0] = 3'd1; data[7:0] = 8'hBB;
    #1 chk("t2b_ready", int'(ready), 3'b001);
    step(); valid = 0;
    #1 chk("t2b_sel", int'(wsel), 1);
    chk("t2b_data", int'(wdata), 8'hBB);
    valid = 3'b100; sel[8:6] = 3'd3; data[23:16] = 8'h44;
    step(); valid = 0;
    step();
    valid = 3'b111; sel = {3'd2, 3'd1, 3'd0}; data = 24'h332211;
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_ready", int'(ready), 1 << (i % 3));
      if (i > 0) begin
        chk("t3_we", int'(we), 1);
        chk("t3_data", int'(wdata), 8'h11 * ((i - 1) % 3 + 1));
      end
      step();
    end
    valid = 0;
    #1 chk("t3_last", int'(wdata), 8'h33);
    step();
    valid = 3'b100; sel[8:6] = 3'd7; data[23:16] = 8'hCC;
    #1 chk("t4_ready", int'(ready), 3'b100);
    step(); valid = 0;
    #1 chk("t4_we", int'(we), 0);
    chk("t4_err", int'(err), 1);
    chk("t4_src", int'(src), 2);
    valid = 3'b001; sel[2:0] = 3'd6;
    #1 chk("t4b_ready", int'(ready), 3'b001);
    step(); valid = 0;
    #1 chk("t4b_src", int'(src), 2);
    chk("t4b_we", int'(we), 0);
    eclr = 1;
    step(); eclr = 0;
    #1 chk("t4c_err", int'(err), 0);
    chk("t4c_src", int'(src), 2);
    clr = 1; valid = 3'b001; sel[2:0] = 3'd4; data[7:0] = 8'h5A;
    #1 chk("t5_ready0", int'(ready), 0);
    step(); clr = 0;
    for (int i = 1; i <= 6; i++) begin
      #1 chk("t5_ready", int'(ready), 0);
      chk("t5_busy", int'(busy), 1);
      if (i >= 2) begin
        chk("t5_we", int'(we), 1);
        chk("t5_sel", int'(wsel), i - 2);
        chk("t5_data", int'(wdata), 0);
      end
      step();
    end
    #1 chk("t5_grant", int'(ready), 3'b001);
    chk("t5_busy_off", int'(busy), 0);
    chk("t5_last_sel", int'(wsel), 5);
    step(); valid = 0;
    #1 chk("t5_wr_we", int'(we), 1);
    chk("t5_wr_sel", int'(wsel), 4);
    chk("t5_wr_data", int'(wdata), 8'h5A);
    clr = 1;
    step(); clr = 0;
    step();
    step();
    rst = 1;
    step(); rst = 0;
    #1 chk("t6_busy", int'(busy), 0);
    chk("t6_we", int'(we), 0);
    valid = 3'b101;
    #1 chk("t6_ptr", int'(ready), 3'b001);
    valid = 0; clr = 1;
    step(); clr = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      #1 chk("t6_sweep", int'(wsel), i);
      chk("t6_sweep_we", int'(we), 1);
      step();
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
